seq_add_sub: RTL and testbench
==============================

// Module: seq_add_sub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: the sequential successor to the 32-bit combinational ADD.
//  Processes CHUNK bits per clock through a CHUNK-bit carry chain, with the carry kept in a register between chunks.
//  Sits beside the ALU as a small-area add/sub engine.
//  Produces sum/difference plus carry, signed-overflow and zero flags, under a start/ready/done handshake.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CHUNK  8   bits processed per RUN cycle; WIDTH % CHUNK must be 0; CHUNK==WIDTH is legal
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; accepted only when ready=1
//  op_sub     in   1      0: a_in+b_in; 1: a_in-b_in; sampled with start
//  a_in       in   WIDTH  operand A; sampled with start
//  b_in       in   WIDTH  operand B; sampled with start
//  ready      out  1      1 in IDLE and DONE states
//  busy       out  1      1 in RUN state
//  done       out  1      one-cycle pulse; result/flags valid from this cycle on
//  result     out  WIDTH  sum or difference
//  carry_out  out  1      raw carry out of bit WIDTH-1; for sub, 1 = no borrow
//  overflow   out  1      two's-complement signed overflow
//  zero       out  1      1 when result==0
// BEHAVIOUR
//  - NCHUNK = WIDTH/CHUNK.
//  - Elaboration check: if WIDTH % CHUNK != 0 or CHUNK < 1, elaboration fails.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE -> RUN when start=1.
//    - RUN -> DONE after NCHUNK RUN cycles.
//    - DONE -> RUN when start=1; otherwise DONE -> IDLE.
//  - On accept (start & ready):
//    - latch A into a_r; latch B' into b_r, where B' = op_sub ? ~b_in : b_in.
//    - carry register := op_sub; chunk index := 0; clear the working sum register.
//  - Each RUN cycle adds chunk k = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry.
//    - Writes the CHUNK-bit sum into working sum bits [k*CHUNK +: CHUNK].
//    - Updates carry; index increments.
//    - During the last chunk, capture the carry INTO the MSB (c_msb) for the overflow flag.
//  - On the RUN->DONE edge, the result and flags registers load together:
//    - result := working sum; carry_out := final carry; zero := (sum==0);
//    - overflow := c_msb ^ final carry.
//  - Latency: start=1 sampled in cycle T -> done=1 in cycle T+NCHUNK+1.
//    - WIDTH=32, CHUNK=8 -> T+5.
//    - CHUNK=WIDTH -> T+2.
//  - Throughput: accepting start in the DONE cycle gives back-to-back ops, one per NCHUNK+1 cycles.
//  - start while busy=1: ignored, with no effect on operands, state or outputs.
//  - result and flags hold their last values through IDLE and through the next RUN.
//    - They change only on a DONE entry.
//  - Reset values (from any state, including mid-RUN):
//    - state=IDLE; ready=1; busy=0; done=0.
//    - result=0; carry_out=0; overflow=0; zero=0.
//    - An aborted operation produces no done pulse.
//  - rst has priority over start in the same cycle.
//  - op_sub/a_in/b_in changing during RUN: no effect, because operands are registered.
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
//  1. add 0x000000FF+0x00000001 -> result 0x00000100, carry 0, ovf 0, zero 0; done exactly at T+5, width 1 cycle.
//  2. add 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf 1, carry 0.
//     add 0xFFFFFFFF+0x00000001 -> 0x00000000, carry 1, zero 1, ovf 0.
//  3. sub 5-5 -> 0, zero 1, carry 1.
//     sub 0-1 -> 0xFFFFFFFF, carry 0, ovf 0.
//     sub 0x80000000-1 -> 0x7FFFFFFF, ovf 1.
//  4. start pulses every cycle during RUN -> ignored.
//     start held in DONE -> second op accepted; second done at first done+5; results correct for both ops.
//  5. rst asserted in 2nd RUN cycle -> next cycle: ready 1, busy 0, all outputs 0; no done ever pulses for that op.
//  6. Re-run tests 1-3 with CHUNK=32 (done at T+2) and with CHUNK=1 (done at T+33); results identical.

Source files
------------

// File: rtl/seq_add_sub.sv
// ---------------------------------------------------------------------------
// seq_add_sub
// Multi-cycle adder/subtractor. Operands are registered on accept and the
// sum is built CHUNK bits per clock through a CHUNK-bit carry chain. The
// carry is held in a register between chunks. Subtraction is done as
// A + ~B + 1, so carry_out = 1 means "no borrow".
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      request, accepted when ready=1
//   op_sub     in   1      0: a_in+b_in, 1: a_in-b_in (sampled with start)
//   a_in       in   WIDTH  operand A (sampled with start)
//   b_in       in   WIDTH  operand B (sampled with start)
//   ready      out  1      high in IDLE and DONE
//   busy       out  1      high in RUN
//   done       out  1      one-cycle pulse on DONE entry
//   result     out  WIDTH  sum/difference, holds until next DONE entry
//   carry_out  out  1      carry out of bit WIDTH-1
//   overflow   out  1      two's-complement signed overflow
//   zero       out  1      result == 0
// ---------------------------------------------------------------------------
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Elaboration guard on the chunk geometry.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("seq_add_sub: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;    // working sum, filled chunk by chunk
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic [CHUNK-1:0] w_a_chunk [NCHUNK];
    logic [CHUNK-1:0] w_b_chunk [NCHUNK];
    logic [CHUNK-1:0] w_a_sel;
    logic [CHUNK-1:0] w_b_sel;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_c_msb;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Split the operand registers into chunk slices for the index mux, and
    // merge the freshly computed chunk back into the working sum.
    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_a_chunk[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_chunk[gi] = r_b[gi*CHUNK +: CHUNK];
            assign w_sum_next[gi*CHUNK +: CHUNK] =
                (r_idx == IW'(gi)) ? w_chunk_sum[CHUNK-1:0]
                                   : r_sum[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_sel     = w_a_chunk[r_idx];
    assign w_b_sel     = w_b_chunk[r_idx];
    assign w_chunk_sum = {1'b0, w_a_sel} + {1'b0, w_b_sel} + {{CHUNK{1'b0}}, r_carry};

    // Carry into the top bit of this chunk, recovered from the sum bit.
    // Only meaningful on the last chunk, where it is the carry into the MSB.
    assign w_c_msb = w_a_sel[CHUNK-1] ^ w_b_sel[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
    assign w_last  = (r_idx == IW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= op_sub ? ~b_in : b_in;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        // MSB carry and final carry are both available in
                        // this cycle, so all flags load on the same edge.
                        r_state   <= S_DONE;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= w_sum_next;
                        carry_out <= w_chunk_sum[CHUNK];
                        overflow  <= w_c_msb ^ w_chunk_sum[CHUNK];
                        zero      <= (w_sum_next == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_sub.sv
// ---------------------------------------------------------------------------
// tb_seq_add_sub
// Drives three seq_add_sub instances (CHUNK = 8, 32, 1 at WIDTH = 32) with
// directed corner cases and $urandom operands, compares against an
// arithmetic reference model, and checks latency, done width, handshake
// behaviour, back-to-back operation and mid-run reset.
// ---------------------------------------------------------------------------
module tb_seq_add_sub;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v    [3];
    logic        op_v       [3];
    logic [W-1:0] a_v       [3];
    logic [W-1:0] b_v       [3];
    logic        ready_v    [3];
    logic        busy_v     [3];
    logic        done_v     [3];
    logic [W-1:0] result_v  [3];
    logic        carry_v    [3];
    logic        ovf_v      [3];
    logic        zero_v     [3];

    int nch [3] = '{4, 1, 32};
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_add_sub #(.WIDTH(W), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .op_sub(op_v[0]),
        .a_in(a_v[0]), .b_in(b_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(result_v[0]), .carry_out(carry_v[0]),
        .overflow(ovf_v[0]), .zero(zero_v[0]));

    seq_add_sub #(.WIDTH(W), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op_sub(op_v[1]),
        .a_in(a_v[1]), .b_in(b_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .result(result_v[1]), .carry_out(carry_v[1]),
        .overflow(ovf_v[1]), .zero(zero_v[1]));

    seq_add_sub #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .op_sub(op_v[2]),
        .a_in(a_v[2]), .b_in(b_v[2]), .ready(ready_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .result(result_v[2]), .carry_out(carry_v[2]),
        .overflow(ovf_v[2]), .zero(zero_v[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, zero, carry, result} from plain integer arithmetic.
    function automatic logic [34:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned ua, ub, full;
        longint sa, sb, sres;
        logic [W-1:0] res;
        logic cy, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            full = ua + 64'h1_0000_0000 - ub;   // bit 32 set means no borrow
            sres = sa - sb;
        end else begin
            full = ua + ub;
            sres = sa + sb;
        end
        res = full[31:0];
        cy  = full[32];
        ov  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {ov, (res == '0), cy, res};
    endfunction

    task automatic drive(input int d, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_v[d] = 1'b1;
        op_v[d]    = op;
        a_v[d]     = a;
        b_v[d]     = b;
    endtask

    // Called at the negedge where a request has just been driven. Waits for
    // done, checks latency and outputs. With chain=1 the next request is
    // driven in the done cycle (start held high) and the task returns there.
    task automatic wait_done(input int d, input logic [34:0] exp, input bit noise,
                             input bit chain, input logic cop,
                             input logic [W-1:0] ca, input logic [W-1:0] cb);
        int cyc = 0;
        bit seen = 0;
        string t;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc++;
            if (cyc == 1) begin
                check($sformatf("d%0d busy_in_run", d), 64'(busy_v[d]), 64'd1);
                check($sformatf("d%0d ready_in_run", d), 64'(ready_v[d]), 64'd0);
            end
            if (done_v[d]) begin
                seen = 1;
                break;
            end
            if (noise && busy_v[d]) begin
                start_v[d] = 1'b1;
                op_v[d]    = $urandom_range(0, 1) != 0;
                a_v[d]     = $urandom;
                b_v[d]     = $urandom;
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        t = $sformatf("d%0d", d);
        check({t, " done_seen"}, 64'(seen), 64'd1);
        check({t, " latency"}, 64'(cyc), 64'(nch[d] + 1));
        $display("[TB] dut%0d op=%0d result=%08h c=%0d v=%0d z=%0d exp=%08h c=%0d v=%0d z=%0d lat=%0d",
                 d, op_v[d], result_v[d], carry_v[d], ovf_v[d], zero_v[d],
                 exp[31:0], exp[32], exp[34], exp[33], cyc);
        check({t, " result"}, 64'(result_v[d]), 64'(exp[31:0]));
        check({t, " carry"}, 64'(carry_v[d]), 64'(exp[32]));
        check({t, " zero"}, 64'(zero_v[d]), 64'(exp[33]));
        check({t, " overflow"}, 64'(ovf_v[d]), 64'(exp[34]));
        if (chain) begin
            drive(d, cop, ca, cb);
        end else begin
            @(negedge clk);
            check({t, " done_width"}, 64'(done_v[d]), 64'd0);
            check({t, " ready_after"}, 64'(ready_v[d]), 64'd1);
            check({t, " result_hold"}, 64'(result_v[d]), 64'(exp[31:0]));
        end
    endtask

    task automatic one_op(input int d, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit noise);
        drive(d, op, a, b);
        wait_done(d, model(op, a, b), noise, 1'b0, 1'b0, '0, '0);
    endtask

    logic        dir_op [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] dir_a [7] = '{32'h0000_00FF, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                32'd5, 32'd0, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] dir_b [7] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                32'd5, 32'd1, 32'd1, 32'h8000_0000};

    initial begin
        int wd;
        logic [W-1:0] a1, b1, a2, b2;
        logic o1, o2;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            op_v[d]    = 1'b0;
            a_v[d]     = '0;
            b_v[d]     = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d rst_ready", d), 64'(ready_v[d]), 64'd1);
            check($sformatf("d%0d rst_busy", d), 64'(busy_v[d]), 64'd0);
            check($sformatf("d%0d rst_done", d), 64'(done_v[d]), 64'd0);
            check($sformatf("d%0d rst_outs", d),
                  {29'd0, carry_v[d], ovf_v[d], zero_v[d], result_v[d]}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases on every chunk size, then random operands.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 7; i++)
                one_op(d, dir_op[i], dir_a[i], dir_b[i], 1'b0);
            for (int i = 0; i < 12; i++)
                one_op(d, $urandom_range(0, 1) != 0, $urandom, $urandom, 1'b0);
        end

        // Start pulses and operand churn during RUN must be ignored.
        for (int i = 0; i < 10; i++)
            one_op(0, $urandom_range(0, 1) != 0, $urandom, $urandom, 1'b1);

        // Back-to-back: second request accepted in the DONE cycle.
        for (int d = 0; d < 3; d++) begin
            o1 = $urandom_range(0, 1) != 0; a1 = $urandom; b1 = $urandom;
            o2 = $urandom_range(0, 1) != 0; a2 = $urandom; b2 = $urandom;
            drive(d, o1, a1, b1);
            wait_done(d, model(o1, a1, b1), 1'b0, 1'b1, o2, a2, b2);
            wait_done(d, model(o2, a2, b2), 1'b0, 1'b0, 1'b0, '0, '0);
        end

        // Reset in the 2nd RUN cycle aborts the op with no done pulse.
        drive(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        @(negedge clk);
        start_v[0] = 1'b0;          // cycle T+1: first RUN cycle
        @(negedge clk);             // cycle T+2: second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", 64'(ready_v[0]), 64'd1);
        check("abort busy", 64'(busy_v[0]), 64'd0);
        check("abort outs", {29'd0, carry_v[0], ovf_v[0], zero_v[0], result_v[0]}, 64'd0);
        wd = 0;
        for (int k = 0; k < 10; k++) begin
            if (done_v[0]) wd++;
            @(negedge clk);
        end
        check("abort no_done", 64'(wd), 64'd0);
        $display("[TB] dut0 abort: done pulses after reset=%0d", wd);

        // Engine still works after the abort.
        one_op(0, 1'b1, 32'h8000_0000, 32'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
